// File: rtl/l1b_read_request_scheduler_if.sv
// Read-select request/issue bundle between trigger logic (master) and the
// L1Buffer read-request scheduler (slave).
interface l1b_read_request_scheduler_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  R3_Req;
  logic [ADDR_WIDTH-1:0] R3_Addr;
  logic                  L1_Req;
  logic [ADDR_WIDTH-1:0] L1_Addr;
  logic                  ClearErr;
  logic                  AI;
  logic                  BI;
  logic [ADDR_WIDTH-1:0] AddressOut1;
  logic [ADDR_WIDTH-1:0] AddressOut2;
  logic                  R3_Full;
  logic                  L1_Full;
  logic                  R3_Overflow;
  logic                  L1_Overflow;
  logic                  Busy;

  modport master (
    output R3_Req, R3_Addr, L1_Req, L1_Addr, ClearErr,
    input  AI, BI, AddressOut1, AddressOut2,
    input  R3_Full, L1_Full, R3_Overflow, L1_Overflow, Busy
  );

  modport slave (
    input  R3_Req, R3_Addr, L1_Req, L1_Addr, ClearErr,
    output AI, BI, AddressOut1, AddressOut2,
    output R3_Full, L1_Full, R3_Overflow, L1_Overflow, Busy
  );
endinterface

// File: rtl/l1b_read_request_scheduler.sv
// L1Buffer read-request scheduler: two request FIFOs (R3, L1), R3-priority
// arbitration with an L1-full override, single-cycle AI/BI issue pulses with
// held addresses, and a minimum SPACING-cycle gap between issues.
module l1b_read_request_scheduler #(
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int SPACING    = 4
) (
  input logic CLK,
  input logic RSTB,
  l1b_read_request_scheduler_if.slave bus
);

  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int PTR_W = PW + 1;
  localparam int CW    = $clog2(SPACING + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_GAP
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_gap;
  logic                  r_ai;
  logic                  r_bi;
  logic [ADDR_WIDTH-1:0] r_out1;
  logic [ADDR_WIDTH-1:0] r_out2;
  logic                  r_ovf3;
  logic                  r_ovf1;

  logic [ADDR_WIDTH-1:0] r_mem3 [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] r_mem1 [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wp3, r_rp3, r_wp1, r_rp1;

  logic w_empty3, w_empty1, w_full3, w_full1, w_any;
  logic w_go, w_pick1, w_pop3, w_pop1;
  logic w_push3, w_push1, w_drop3, w_drop1;
  logic [ADDR_WIDTH-1:0] w_head3, w_head1;

  assign w_empty3 = (r_wp3 == r_rp3);
  assign w_empty1 = (r_wp1 == r_rp1);
  assign w_full3  = (r_wp3[PW] != r_rp3[PW]) && (r_wp3[PW-1:0] == r_rp3[PW-1:0]);
  assign w_full1  = (r_wp1[PW] != r_rp1[PW]) && (r_wp1[PW-1:0] == r_rp1[PW-1:0]);
  assign w_any    = !w_empty3 || !w_empty1;
  assign w_head3  = r_mem3[r_rp3[PW-1:0]];
  assign w_head1  = r_mem1[r_rp1[PW-1:0]];

  // An issue is launched on the edge that enters ISSUE, so the pulse, the pop
  // and the address load all land on the same edge; that edge comes either
  // from IDLE or from the last GAP cycle.
  assign w_go    = w_any && ((r_state == S_IDLE) || ((r_state == S_GAP) && (r_gap == CW'(1))));
  assign w_pick1 = !w_empty1 && (w_empty3 || (w_full1 && !w_full3));
  assign w_pop3  = w_go && !w_pick1;
  assign w_pop1  = w_go && w_pick1;

  // A pop on a full queue frees the slot the simultaneous push needs.
  assign w_push3 = bus.R3_Req && (!w_full3 || w_pop3);
  assign w_push1 = bus.L1_Req && (!w_full1 || w_pop1);
  assign w_drop3 = bus.R3_Req && w_full3 && !w_pop3;
  assign w_drop1 = bus.L1_Req && w_full1 && !w_pop1;

  // Queue pointers and sticky overflow flags (set wins over ClearErr).
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_wp3  <= '0;
      r_rp3  <= '0;
      r_wp1  <= '0;
      r_rp1  <= '0;
      r_ovf3 <= 1'b0;
      r_ovf1 <= 1'b0;
    end else begin
      if (w_push3) r_wp3 <= r_wp3 + PTR_W'(1);
      if (w_pop3)  r_rp3 <= r_rp3 + PTR_W'(1);
      if (w_push1) r_wp1 <= r_wp1 + PTR_W'(1);
      if (w_pop1)  r_rp1 <= r_rp1 + PTR_W'(1);
      r_ovf3 <= (r_ovf3 && !bus.ClearErr) || w_drop3;
      r_ovf1 <= (r_ovf1 && !bus.ClearErr) || w_drop1;
    end
  end

  // Queue storage; contents are only observed through valid pointers.
  always_ff @(posedge CLK) begin
    if (w_push3) r_mem3[r_wp3[PW-1:0]] <= bus.R3_Addr;
    if (w_push1) r_mem1[r_wp1[PW-1:0]] <= bus.L1_Addr;
  end

  // Issue FSM with registered pulses and held addresses.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state <= S_IDLE;
      r_gap   <= '0;
      r_ai    <= 1'b0;
      r_bi    <= 1'b0;
      r_out1  <= '0;
      r_out2  <= '0;
    end else begin
      r_ai <= 1'b0;
      r_bi <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_go) r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          r_gap   <= CW'(SPACING - 1);
          r_state <= S_GAP;
        end
        S_GAP: begin
          r_gap <= r_gap - CW'(1);
          if (r_gap == CW'(1)) r_state <= w_go ? S_ISSUE : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_go) begin
        r_ai <= !w_pick1;
        r_bi <= w_pick1;
        if (w_pick1) r_out2 <= w_head1;
        else         r_out1 <= w_head3;
      end
    end
  end

  assign bus.AI          = r_ai;
  assign bus.BI          = r_bi;
  assign bus.AddressOut1 = r_out1;
  assign bus.AddressOut2 = r_out2;
  assign bus.R3_Full     = w_full3;
  assign bus.L1_Full     = w_full1;
  assign bus.R3_Overflow = r_ovf3;
  assign bus.L1_Overflow = r_ovf1;
  assign bus.Busy        = w_any || (r_state != S_IDLE);

endmodule

// File: tb/tb_l1b_read_request_scheduler.sv
// Bench for l1b_read_request_scheduler: directed scenarios with literal
// expectations plus randomized pushes, all checked every cycle against a
// queue-based reference model.
module tb_l1b_read_request_scheduler;

  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int SPC   = 4;

  logic CLK = 1'b0;
  logic RSTB;

  l1b_read_request_scheduler_if #(.ADDR_WIDTH(AW)) bus ();

  l1b_read_request_scheduler #(
    .ADDR_WIDTH(AW),
    .FIFO_DEPTH(DEPTH),
    .SPACING   (SPC)
  ) dut (
    .CLK (CLK),
    .RSTB(RSTB),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-queue FIFOs, cycle count and last issue cycle.
  int q3[$];
  int q1[$];
  int m_cyc;
  int m_last;
  int e_ai, e_bi, e_o1, e_o2, e_ov3, e_ov1;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (model cycle %0d)", nm, act, exp, m_cyc);
    end
  endtask

  task automatic model_reset();
    q3.delete();
    q1.delete();
    m_cyc  = 0;
    m_last = -1000;
    e_ai = 0; e_bi = 0; e_o1 = 0; e_o2 = 0; e_ov3 = 0; e_ov1 = 0;
  endtask

  // One clock edge: an issue happens when SPACING cycles have elapsed since
  // the last one and something was queued during the previous cycle.
  task automatic model_edge(input bit rst, input bit r3, input int a3,
                            input bit l1, input int a1, input bit clr);
    bit d3, d1;
    if (!rst) begin
      model_reset();
      return;
    end
    m_cyc++;
    e_ai = 0;
    e_bi = 0;
    if ((m_cyc - m_last >= SPC) && (q3.size() != 0 || q1.size() != 0)) begin
      if (q1.size() != 0 && (q3.size() == 0 || (q1.size() == DEPTH && q3.size() < DEPTH))) begin
        e_bi = 1;
        e_o2 = q1.pop_front();
      end else begin
        e_ai = 1;
        e_o1 = q3.pop_front();
      end
      m_last = m_cyc;
    end
    d3 = 0;
    d1 = 0;
    if (r3) begin
      if (q3.size() < DEPTH) q3.push_back(a3);
      else d3 = 1;
    end
    if (l1) begin
      if (q1.size() < DEPTH) q1.push_back(a1);
      else d1 = 1;
    end
    e_ov3 = ((e_ov3 != 0) && !clr) || d3;
    e_ov1 = ((e_ov1 != 0) && !clr) || d1;
  endtask

  task automatic compare_all();
    int busy;
    busy = (q3.size() != 0 || q1.size() != 0 || (m_cyc - m_last < SPC)) ? 1 : 0;
    chk("AI",          bus.AI,          e_ai);
    chk("BI",          bus.BI,          e_bi);
    chk("AddressOut1", bus.AddressOut1, e_o1);
    chk("AddressOut2", bus.AddressOut2, e_o2);
    chk("R3_Full",     bus.R3_Full,     (q3.size() == DEPTH) ? 1 : 0);
    chk("L1_Full",     bus.L1_Full,     (q1.size() == DEPTH) ? 1 : 0);
    chk("R3_Overflow", bus.R3_Overflow, e_ov3);
    chk("L1_Overflow", bus.L1_Overflow, e_ov1);
    chk("Busy",        bus.Busy,        busy);
  endtask

  // Drive one cycle of inputs, advance the model on the edge, compare after.
  task automatic step(input bit rst, input bit r3, input logic [7:0] a3,
                      input bit l1, input logic [7:0] a1, input bit clr);
    RSTB         = rst;
    bus.R3_Req   = r3;
    bus.R3_Addr  = a3;
    bus.L1_Req   = l1;
    bus.L1_Addr  = a1;
    bus.ClearErr = clr;
    @(posedge CLK);
    model_edge(rst, r3, int'(a3), l1, int'(a1), clr);
    @(negedge CLK);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  // Backlog on L1 behind an R3 issue: fifth L1 push overflows.
  task automatic l1_overflow_run(input bit clr5);
    step(1, 1, 8'h10, 1, 8'h01, 0);          // cycle 1 after
    step(1, 0, 8'h00, 1, 8'h02, 0);          // c2 (AI 0x10)
    step(1, 0, 8'h00, 1, 8'h03, 0);          // c3
    step(1, 0, 8'h00, 1, 8'h04, 0);          // c4
    chk("t3_l1_full_c4", bus.L1_Full, 1);
    chk("t3_l1_ovf_c4", bus.L1_Overflow, 0);
    step(1, 0, 8'h00, 1, 8'h05, clr5);       // c5
    chk("t3_l1_ovf_c5", bus.L1_Overflow, 1);
    idle(1);                                 // c6
    chk("t3_bi_c6", bus.BI, 1);
    chk("t3_out2_c6", bus.AddressOut2, 8'h01);
    idle(12);                                // c18
    chk("t3_bi_c18", bus.BI, 1);
    chk("t3_out2_c18", bus.AddressOut2, 8'h04);
    idle(4);                                 // c22
    chk("t3_bi_c22", bus.BI, 0);
    chk("t3_out2_c22", bus.AddressOut2, 8'h04);
    chk("t3_busy_c22", bus.Busy, 0);
  endtask

  initial begin
    int pulses;
    int p;
    bit rr, r3, l1, clr;

    RSTB = 1'b0;
    bus.R3_Req = 0; bus.R3_Addr = '0; bus.L1_Req = 0; bus.L1_Addr = '0; bus.ClearErr = 0;
    model_reset();
    #2;
    chk("rst_ai", bus.AI, 0);
    chk("rst_bi", bus.BI, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_out1", bus.AddressOut1, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Single R3 request: pulse two cycles after the push.
    step(1, 1, 8'h2A, 0, 8'h00, 0);          // c1
    chk("t1_ai_c1", bus.AI, 0);
    idle(1);                                 // c2
    chk("t1_ai_c2", bus.AI, 1);
    chk("t1_bi_c2", bus.BI, 0);
    chk("t1_out1_c2", bus.AddressOut1, 8'h2A);
    idle(1);                                 // c3
    chk("t1_ai_c3", bus.AI, 0);
    chk("t1_out1_c3", bus.AddressOut1, 8'h2A);
    idle(8);

    // Simultaneous R3 and L1 pushes.
    step(1, 1, 8'h10, 1, 8'h20, 0);          // c1
    idle(1);                                 // c2
    chk("t2_ai_c2", bus.AI, 1);
    chk("t2_out1_c2", bus.AddressOut1, 8'h10);
    idle(3);                                 // c5
    chk("t2_bi_c5", bus.BI, 0);
    idle(1);                                 // c6
    chk("t2_bi_c6", bus.BI, 1);
    chk("t2_out2_c6", bus.AddressOut2, 8'h20);
    chk("t2_out1_c6", bus.AddressOut1, 8'h10);
    idle(8);

    // L1 overflow, ClearErr, and set-wins on a simultaneous overflow.
    l1_overflow_run(1'b0);
    step(1, 0, 8'h00, 0, 8'h00, 1);
    chk("t4_clear", bus.L1_Overflow, 0);
    l1_overflow_run(1'b1);
    step(1, 0, 8'h00, 0, 8'h00, 1);
    chk("t4_clear2", bus.L1_Overflow, 0);

    // Full-L1 override of R3 priority.
    step(1, 1, 8'h33, 0, 8'h00, 0);          // c1
    step(1, 0, 8'h00, 1, 8'h41, 0);          // c2 (AI 0x33)
    step(1, 0, 8'h00, 1, 8'h42, 0);          // c3
    step(1, 1, 8'h34, 1, 8'h43, 0);          // c4
    step(1, 0, 8'h00, 1, 8'h44, 0);          // c5
    idle(1);                                 // c6
    chk("t4_bi_c6", bus.BI, 1);
    chk("t4_ai_c6", bus.AI, 0);
    chk("t4_out2_c6", bus.AddressOut2, 8'h41);
    chk("t4_out1_c6", bus.AddressOut1, 8'h33);
    idle(4);                                 // c10
    chk("t4_ai_c10", bus.AI, 1);
    chk("t4_out1_c10", bus.AddressOut1, 8'h34);
    idle(4);                                 // c14
    chk("t4_bi_c14", bus.BI, 1);
    chk("t4_out2_c14", bus.AddressOut2, 8'h42);
    idle(20);

    // Asynchronous reset during GAP with three requests pending.
    step(1, 1, 8'h51, 1, 8'h61, 0);          // c1
    step(1, 1, 8'h52, 1, 8'h62, 0);          // c2 (AI 0x51)
    idle(1);                                 // c3, in GAP
    chk("t5_busy_pre", bus.Busy, 1);
    RSTB = 1'b0;
    #1;
    chk("t5_ai", bus.AI, 0);
    chk("t5_bi", bus.BI, 0);
    chk("t5_out1", bus.AddressOut1, 0);
    chk("t5_out2", bus.AddressOut2, 0);
    chk("t5_l1_ovf", bus.L1_Overflow, 0);
    chk("t5_busy", bus.Busy, 0);
    model_reset();
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      idle(1);
      if (bus.AI || bus.BI) pulses++;
    end
    chk("t5_no_pulse_after_reset", pulses, 0);

    // Randomized traffic with varying density and rare resets.
    p = 30;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) p = $urandom_range(5, 70);
      rr  = ($urandom_range(0, 999) >= 2);
      r3  = ($urandom_range(0, 99) < p);
      l1  = ($urandom_range(0, 99) < p);
      clr = ($urandom_range(0, 99) < 3);
      step(rr, r3, 8'($urandom_range(0, 255)), l1, 8'($urandom_range(0, 255)), clr);
    end
    idle(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
